// File: rtl/aes_stream_adapter.sv
// Purpose: packs 32-bit words into AES-128 key/plaintext blocks, runs the core, streams back the ciphertext.
// Latency: 4th data word at edge E0 -> core_start high E0+1..E0+CORE_LATENCY -> m_valid from E0+CORE_LATENCY+1.
// Backpressure: s_ready only in COLLECT; m_ready low holds DRAIN (and stalls input) indefinitely.
module aes_stream_adapter #(
    parameter int CORE_LATENCY = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_is_key,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [31:0]  m_data,
    output logic         key_loaded,
    output logic         busy,
    output logic [127:0] core_plain_text,
    output logic [127:0] core_key,
    output logic         core_start,
    output logic         core_restart,
    input  logic [127:0] core_cipher_text
);

    localparam int LW = (CORE_LATENCY > 1) ? $clog2(CORE_LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_RUN     = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      word_cnt_q, word_cnt_d;
    logic            grp_key_q, grp_key_d;
    logic [95:0]     stage_q, stage_d;
    logic [127:0]    key_q, key_d;
    logic [127:0]    pt_q, pt_d;
    logic            key_loaded_q, key_loaded_d;
    logic [LW-1:0]   lat_cnt_q, lat_cnt_d;
    logic [1:0]      out_cnt_q, out_cnt_d;
    logic [127:0]    out_q, out_d;
    logic            restart_q, restart_d;

    logic            s_fire;
    logic            m_fire;
    logic            grp_type;
    logic [127:0]    blk;

    // Handshake qualifiers: nothing transfers while reset is asserted.
    always_comb begin
        s_ready = (state_q == ST_COLLECT) && !reset;
        m_valid = (state_q == ST_DRAIN) && !reset;
        s_fire  = s_valid && s_ready;
        m_fire  = m_valid && m_ready;
    end

    // Next-state logic: word grouping, latency count and output sequencing.
    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        grp_key_d    = grp_key_q;
        stage_d      = stage_q;
        key_d        = key_q;
        pt_d         = pt_q;
        key_loaded_d = key_loaded_q;
        lat_cnt_d    = lat_cnt_q;
        out_cnt_d    = out_cnt_q;
        out_d        = out_q;
        restart_d    = 1'b0;
        // Group type is taken from the first word only; later words inherit it.
        grp_type     = (word_cnt_q == 2'd0) ? s_is_key : grp_key_q;
        blk          = {stage_q, s_data};

        case (state_q)
            ST_COLLECT: begin
                if (s_fire) begin
                    grp_key_d  = grp_type;
                    word_cnt_d = word_cnt_q + 2'd1;
                    case (word_cnt_q)
                        2'd0:    stage_d[95:64] = s_data;
                        2'd1:    stage_d[63:32] = s_data;
                        2'd2:    stage_d[31:0]  = s_data;
                        default: begin
                            // Only a complete group ever reaches the core-facing registers.
                            if (grp_type) begin
                                key_d        = blk;
                                key_loaded_d = 1'b1;
                            end else begin
                                pt_d      = blk;
                                lat_cnt_d = '0;
                                state_d   = ST_RUN;
                            end
                        end
                    endcase
                end
            end
            ST_RUN: begin
                lat_cnt_d = lat_cnt_q + LW'(1);
                if (lat_cnt_q == LW'(CORE_LATENCY - 1)) begin
                    out_d     = core_cipher_text;
                    lat_cnt_d = '0;
                    restart_d = 1'b1;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (m_fire) begin
                    out_cnt_d = out_cnt_q + 2'd1;
                    if (out_cnt_q == 2'd3) begin
                        out_cnt_d = 2'd0;
                        state_d   = ST_COLLECT;
                    end
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    // State register; reset discards partial groups, pending ciphertext and the key.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_COLLECT;
            word_cnt_q   <= '0;
            grp_key_q    <= 1'b0;
            stage_q      <= '0;
            key_q        <= '0;
            pt_q         <= '0;
            key_loaded_q <= 1'b0;
            lat_cnt_q    <= '0;
            out_cnt_q    <= '0;
            out_q        <= '0;
            restart_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            grp_key_q    <= grp_key_d;
            stage_q      <= stage_d;
            key_q        <= key_d;
            pt_q         <= pt_d;
            key_loaded_q <= key_loaded_d;
            lat_cnt_q    <= lat_cnt_d;
            out_cnt_q    <= out_cnt_d;
            out_q        <= out_d;
            restart_q    <= restart_d;
        end
    end

    // Output word select: most significant word first.
    always_comb begin
        case (out_cnt_q)
            2'd0:    m_data = out_q[127:96];
            2'd1:    m_data = out_q[95:64];
            2'd2:    m_data = out_q[63:32];
            default: m_data = out_q[31:0];
        endcase
        core_start      = (state_q == ST_RUN);
        core_restart    = restart_q;
        busy            = (state_q != ST_COLLECT);
        key_loaded      = key_loaded_q;
        core_key        = key_q;
        core_plain_text = pt_q;
    end

endmodule

// File: tb/tb_aes_stream_adapter.sv
// Purpose: randomized self-checking bench for aes_stream_adapter with a stand-in AES core.
// Latency: stand-in core presents a valid result only in the CORE_LATENCY-th start cycle.
// Backpressure: m_ready driven per block as always-high, random, or a scripted 5-cycle stall.
module tb_aes_stream_adapter;

    localparam int L = 11;
    localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         s_is_key;
    logic         m_valid;
    logic         m_ready;
    logic [31:0]  m_data;
    logic         key_loaded;
    logic         busy;
    logic [127:0] core_plain_text;
    logic [127:0] core_key;
    logic         core_start;
    logic         core_restart;
    logic [127:0] core_cipher_text;

    aes_stream_adapter #(.CORE_LATENCY(L)) dut (
        .clk              (clk),
        .reset            (reset),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .s_is_key         (s_is_key),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .key_loaded       (key_loaded),
        .busy             (busy),
        .core_plain_text  (core_plain_text),
        .core_key         (core_key),
        .core_start       (core_start),
        .core_restart     (core_restart),
        .core_cipher_text (core_cipher_text)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int c0     = 0;

    // Reference state: key as seen by the system, and queue of expected output words.
    logic [127:0] mkey;
    logic [31:0]  expq[$];

    // Stand-in core: the real FIPS-197 vector plus a keyed mixing function otherwise.
    function automatic logic [127:0] fcore(input logic [127:0] k, input logic [127:0] p);
        if (k == FK && p == FP) return FC;
        return {p[95:0], p[127:96]} ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    int start_cnt = 0;
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        start_cnt <= core_start ? start_cnt + 1 : 0;
    end
    // Result is only correct during the L-th consecutive start cycle; garbage otherwise.
    assign core_cipher_text = (core_start && start_cnt == L - 1) ?
                              fcore(core_key, core_plain_text) :
                              fcore(core_key, core_plain_text) ^ 128'hdeadbeef_cafef00d_01234567_89abcdef;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Output monitor: scoreboard, first-valid latency, start length, restart pulse, hold stability.
    int   run_len = 0;
    int   rst_pulses = 0;
    int   hs_cnt = 0;
    logic mv_prev = 1'b0;
    logic hold_pending = 1'b0;
    logic [31:0] held;
    always @(negedge clk) begin
        if (reset) begin
            run_len = 0; rst_pulses = 0; hs_cnt = 0; mv_prev = 1'b0; hold_pending = 1'b0;
        end else begin
            if (core_start) run_len++;
            if (core_restart) rst_pulses++;
            if (m_valid && !mv_prev) begin
                chk("first_valid_latency", cyc - c0, L);
                chk("start_length", run_len, L);
                run_len = 0;
            end
            if (m_valid && hold_pending) chk("m_data_hold", m_data, held);
            hold_pending = m_valid && !m_ready;
            held = m_data;
            if (m_valid) chk("s_ready_in_drain", s_ready, 1'b0);
            if (m_valid && m_ready) begin
                if (expq.size() == 0) chk("unexpected_word", m_data, 'x);
                else chk("m_data", m_data, expq.pop_front());
                hs_cnt++;
                if (hs_cnt == 4) begin
                    chk("restart_once", rst_pulses, 1);
                    rst_pulses = 0;
                    hs_cnt = 0;
                end
            end
            mv_prev = m_valid;
        end
    end

    task automatic send_word(input logic [31:0] d, input logic k, input int gap);
        int n = 0;
        repeat (gap) begin
            s_valid = 1'b0; s_data = $urandom; s_is_key = 1'($urandom);
            @(posedge clk); #1;
        end
        s_valid = 1'b1; s_data = d; s_is_key = k;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 300) begin
                chk("s_ready_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic send_group(input logic isk, input logic [127:0] b, input bit toggle, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            send_word(b[127 - 32*i -: 32], (i != 0 && toggle) ? ~isk : isk,
                      gaps ? int'($urandom_range(0, 2)) : 0);
        end
        c0 = cyc;
        if (isk) mkey = b;
        else begin
            logic [127:0] ct = fcore(mkey, b);
            for (int i = 0; i < 4; i++) expq.push_back(ct[127 - 32*i -: 32]);
        end
    endtask

    // mode 0: m_ready high; 1: random; 2: 5-cycle stall on word 2 (FIPS block only)
    task automatic drain(input int mode);
        int hs = 0;
        int n = 0;
        int stall = 0;
        while (hs < 4 && n < 500) begin
            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = 1'($urandom_range(0, 1));
                default: begin
                    m_ready = !(hs == 2 && stall < 5);
                    if (hs == 2 && stall < 5) stall++;
                end
            endcase
            @(negedge clk);
            if (mode == 2 && m_valid && !m_ready) begin
                chk("bp_hold_word", m_data, 32'hd8cdb780);
                chk("bp_s_ready", s_ready, 1'b0);
            end
            if (m_valid && m_ready) hs++;
            @(posedge clk); #1;
            n++;
        end
        if (hs < 4) chk("drain_timeout", hs, 4);
        m_ready = 1'b0;
    endtask

    task automatic do_reset(input int ncyc);
        reset = 1'b1;
        s_valid = 1'b1; s_data = $urandom; s_is_key = 1'b1;
        m_ready = 1'b1;
        repeat (ncyc - 1) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rst_cycle_s_ready", s_ready, 1'b0);
        chk("rst_cycle_m_valid", m_valid, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        mkey = '0;
        expq.delete();
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 32'h0);
        chk("rst_key_loaded", key_loaded, 1'b0);
        chk("rst_core_start", core_start, 1'b0);
        chk("rst_core_restart", core_restart, 1'b0);
        chk("rst_core_key", core_key, 128'h0);
        chk("rst_core_pt", core_plain_text, 128'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [127:0] rk;
        logic [127:0] rp;
        int c_a;
        bit saw_mv;
        reset = 1'b1; s_valid = 1'b0; s_data = '0; s_is_key = 1'b0; m_ready = 1'b0;
        mkey = '0;
        @(posedge clk); #1;
        do_reset(2);

        // FIPS-197 vector
        send_group(1'b1, FK, 1'b0, 1'b0);
        chk("key_loaded_set", key_loaded, 1'b1);
        chk("core_key_fips", core_key, FK);
        send_group(1'b0, FP, 1'b0, 1'b0);
        chk("core_pt_fips", core_plain_text, FP);
        drain(0);

        // Key persistence with a scripted stall on word 2
        send_group(1'b0, FP, 1'b0, 1'b0);
        drain(2);
        chk("key_persist", key_loaded, 1'b1);

        // Back-to-back throughput: 4 + L + 4 cycles per block
        send_group(1'b0, FP, 1'b0, 1'b0);
        c_a = c0;
        drain(0);
        rp = {$urandom, $urandom, $urandom, $urandom};
        send_group(1'b0, rp, 1'b0, 1'b0);
        chk("throughput", c0 - c_a, 4 + L + 4);
        drain(0);

        // Group-type latch: s_is_key toggled on words 1..3
        rk = {$urandom, $urandom, $urandom, $urandom};
        send_group(1'b1, rk, 1'b1, 1'b0);
        chk("toggle_key_loaded", core_key, rk);
        send_group(1'b0, FP, 1'b1, 1'b0);
        drain(0);
        send_group(1'b1, FK, 1'b1, 1'b0);
        send_group(1'b0, FP, 1'b0, 1'b0);
        drain(1);

        // Partial key group never touches core_key; reset clears it
        send_word(32'h11111111, 1'b1, 0);
        send_word(32'h22222222, 1'b1, 0);
        chk("partial_key_untouched", core_key, FK);
        do_reset(1);
        chk("partial_then_reset_key", core_key, 128'h0);
        send_group(1'b0, FP, 1'b0, 1'b0);
        drain(0);

        // Mid-run reset, then a data-only block with the all-zero key
        send_group(1'b1, FK, 1'b0, 1'b0);
        send_group(1'b0, FP, 1'b0, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        chk("mid_run_busy", busy, 1'b1);
        do_reset(1);
        saw_mv = 1'b0;
        m_ready = 1'b1;
        repeat (L + 6) begin
            @(negedge clk);
            if (m_valid) saw_mv = 1'b1;
            @(posedge clk); #1;
        end
        chk("no_valid_after_abort", saw_mv, 1'b0);
        m_ready = 1'b0;
        send_group(1'b0, FP, 1'b0, 1'b0);
        chk("zero_key_run", core_key, 128'h0);
        drain(0);

        // Randomized blocks: optional key reload, gaps, random backpressure
        for (int b = 0; b < 10; b++) begin
            if ($urandom_range(0, 1) == 1) begin
                rk = {$urandom, $urandom, $urandom, $urandom};
                send_group(1'b1, rk, 1'($urandom), 1'b1);
            end
            rp = {$urandom, $urandom, $urandom, $urandom};
            send_group(1'b0, rp, 1'($urandom), 1'b1);
            drain(1);
        end

        chk("scoreboard_empty", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
